weight_prefetch_fifo_v2: RTL
============================

Name: weight_prefetch_fifo_v2

Overview:
- Parametrised successor of the single-region DDR weight prefetcher.
- Streams weight bursts from DDR into an internal synchronous FIFO for the transformer weight consumer.
- Selects one of NUM_REGIONS weight regions (Q, K, V, MLP, ...) at run time, and supports cyclic or one-shot streaming.
- Handles abort/flush cleanly, including while a burst is in flight.

Parameters:
- DATA_WIDTH, 64, DDR beat and weight word width in bits (power of 2, at least 8).
- ADDR_SIZE, 32, DDR byte address width.
- LEN_WIDTH, 10, burst length field width.
- BURST_LEN, 32, beats per DDR burst.
- FIFO_DEPTH, 512, internal FIFO words (power of 2, at least 2*BURST_LEN).
- PROG_EMPTY, 64, o_weight_ready deasserts when the FIFO count is below this value.
- NUM_REGIONS, 4, number of selectable weight regions.
- BASE_ADDR, 0, byte address of region 0.
- REGION_STRIDE, 147456, byte distance between region bases.
- REGION_BURSTS, 576, bursts per region.
- WRAP_MODE, 1, 1 = cyclic restart at the region end; 0 = stop after the last burst.

Ports:
- s_clk, in, 1, clock; all logic on the rising edge.
- s_rst_n, in, 1, synchronous active-low reset.
- i_region_sel, in, max(1,clog2(NUM_REGIONS)), region to stream; sampled on i_start.
- i_start, in, 1, one-cycle pulse to begin streaming the selected region.
- rd_burst_data, in, DATA_WIDTH, DDR read beat.
- rd_burst_addr, out, ADDR_SIZE, burst start byte address.
- rd_burst_len, out, LEN_WIDTH, constant BURST_LEN.
- rd_burst_req, out, 1, burst request, level.
- rd_burst_valid, in, 1, beat valid.
- rd_burst_finish, in, 1, last-beat/complete pulse.
- o_weight_out, out, DATA_WIDTH, FIFO head, first-word-fall-through.
- i_weight_valid, in, 1, consumer pop.
- o_weight_ready, out, 1, FIFO count at least PROG_EMPTY (level, not a handshake).
- o_empty, out, 1, FIFO count equals 0.
- load_w_finish, in, 1, abort/flush pulse.
- o_busy, out, 1, FSM not in IDLE.
- o_region_done, out, 1, one-cycle pulse when the last burst of a region completes.

Behaviour:
- Reset (s_rst_n=0 at an edge) sets the following:
  - FSM to IDLE.
  - rd_burst_req=0 and rd_burst_addr=BASE_ADDR.
  - FIFO pointers and count to 0, so o_empty=1 and o_weight_ready=0.
  - o_weight_out=0, o_busy=0, o_region_done=0.
  - Burst counter to 0.
  - Reset has priority over every other input.
- Region base = BASE_ADDR + i_region_sel*REGION_STRIDE, latched on i_start. i_start outside IDLE is ignored. A region index at or above NUM_REGIONS is clamped to NUM_REGIONS-1.
- FSM states: IDLE, CHECK, REQ, DATA, DRAIN, FLUSH.
  - IDLE -> CHECK on i_start; rd_burst_addr is loaded with the region base.
  - CHECK -> REQ when free space (FIFO_DEPTH - count) is at least BURST_LEN. Free space counts committed words only, so no overflow is possible.
  - REQ asserts rd_burst_req. It holds until the first rd_burst_valid or rd_burst_finish, then goes to DATA.
  - DATA writes each beat while rd_burst_valid=1.
  - On rd_burst_finish in DATA, rd_burst_req drops (already 0 after the first beat) and the burst counter increments.
    - If the counter equals REGION_BURSTS-1: o_region_done pulses for one cycle. With WRAP_MODE=1, the address returns to the region base and the FSM goes to CHECK. With WRAP_MODE=0, the FSM goes to IDLE.
    - Otherwise: rd_burst_addr += BURST_LEN*(DATA_WIDTH/8) and the FSM goes to CHECK.
  - load_w_finish while in REQ or DATA -> DRAIN. DRAIN discards remaining beats without writing the FIFO, then goes to FLUSH on rd_burst_finish.
  - load_w_finish in CHECK or IDLE -> FLUSH directly.
  - FLUSH (one cycle): clears the FIFO and burst counter, sets rd_burst_addr to the latched base, then goes to CHECK if started and not WRAP_MODE=0-completed, else IDLE.
  - A pending load_w_finish is never lost.
- FIFO behaviour:
  - Simultaneous push and pop in the same cycle leaves the count unchanged.
  - A pop with o_empty=1 is ignored; the count stays at 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - o_weight_out updates the cycle after a pop, or the cycle after the first write into an empty FIFO.
- A write into a full FIFO cannot occur by construction. The bench asserts this.

Optional Feature:
- Macro WEIGHT_FIFO_STAT_EN. When defined, the block adds the following:
  - Output o_underflow_cnt [15:0]: counts pops issued while o_empty=1.
  - Output o_burst_cnt [31:0]: total completed bursts.
  - Both saturate, clear on reset, and clear on i_start.
- When not defined, these ports and this logic are absent, and behaviour is otherwise identical.

Test Plan:
- Test parameters: BURST_LEN=4, FIFO_DEPTH=16, DATA_WIDTH=64, REGION_BURSTS=3, REGION_STRIDE=0x100, WRAP_MODE=1.
- Region select and address sequence: i_start with region 2 -> addresses 0x200, 0x220, 0x240, then 0x200. o_region_done pulses once per 3 bursts. Data order matches the DDR model.
- Backpressure: no pops -> exactly 4 bursts are requested (16 words). rd_burst_req stays 0 until 4 pops free space. No full-write occurs.
- Abort mid-burst: load_w_finish after beat 2 of burst 1 -> beats 3 and 4 are discarded, the FIFO empties (o_empty=1), and the next request is at the region base 0x200.
- Underflow and simultaneous events: pop on empty -> count stays 0 (o_underflow_cnt=1 with WEIGHT_FIFO_STAT_EN). Push and pop in the same cycle at count 5 -> count stays 5.
- One-shot and reset: with WRAP_MODE=0, after 3 bursts the FSM is IDLE and o_busy=0. Asserting s_rst_n=0 during DATA -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/weight_prefetch_fifo_v2_if.sv
// Bus bundle for weight_prefetch_fifo_v2: DDR burst read channel plus the
// weight consumer side of the internal FIFO.
// master = prefetcher, slave = DDR controller / consumer.
interface weight_prefetch_fifo_v2_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_SIZE  = 32,
    parameter int LEN_WIDTH  = 10
);
    logic [DATA_WIDTH-1:0] rd_burst_data;
    logic [ADDR_SIZE-1:0]  rd_burst_addr;
    logic [LEN_WIDTH-1:0]  rd_burst_len;
    logic                  rd_burst_req;
    logic                  rd_burst_valid;
    logic                  rd_burst_finish;
    logic [DATA_WIDTH-1:0] o_weight_out;
    logic                  i_weight_valid;
    logic                  o_weight_ready;
    logic                  o_empty;

    modport master (
        input  rd_burst_data, rd_burst_valid, rd_burst_finish, i_weight_valid,
        output rd_burst_addr, rd_burst_len, rd_burst_req,
               o_weight_out, o_weight_ready, o_empty
    );

    modport slave (
        output rd_burst_data, rd_burst_valid, rd_burst_finish, i_weight_valid,
        input  rd_burst_addr, rd_burst_len, rd_burst_req,
               o_weight_out, o_weight_ready, o_empty
    );
endinterface

// File: rtl/weight_prefetch_fifo_v2.sv
// weight_prefetch_fifo_v2: streams DDR weight bursts of a run-time selected
// region into a first-word-fall-through FIFO, cyclic or one-shot, with
// abort/flush support while a burst is in flight.
// Optional statistics counters are compiled in with WEIGHT_FIFO_STAT_EN.
module weight_prefetch_fifo_v2 #(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_SIZE     = 32,
    parameter int LEN_WIDTH     = 10,
    parameter int BURST_LEN     = 32,
    parameter int FIFO_DEPTH    = 512,
    parameter int PROG_EMPTY    = 64,
    parameter int NUM_REGIONS   = 4,
    parameter int BASE_ADDR     = 0,
    parameter int REGION_STRIDE = 147456,
    parameter int REGION_BURSTS = 576,
    parameter int WRAP_MODE     = 1,
    localparam int SEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic             s_clk,
    input  logic             s_rst_n,
    input  logic [SEL_W-1:0] i_region_sel,
    input  logic             i_start,
    input  logic             load_w_finish,
    weight_prefetch_fifo_v2_if.master bus,
    output logic             o_busy,
    output logic             o_region_done
`ifdef WEIGHT_FIFO_STAT_EN
    ,
    output logic [15:0]      o_underflow_cnt,
    output logic [31:0]      o_burst_cnt
`endif
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = (REGION_BURSTS > 1) ? $clog2(REGION_BURSTS) : 1;
    localparam logic [ADDR_SIZE-1:0] BASE_A      = ADDR_SIZE'(BASE_ADDR);
    localparam logic [ADDR_SIZE-1:0] BURST_BYTES = ADDR_SIZE'(BURST_LEN * (DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DRAIN, FLUSH} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] head;
    logic [AW-1:0]         wr_ptr, rd_ptr, rd_nx;
    logic [CW-1:0]         count;
    logic [ADDR_SIZE-1:0]  base, addr, region_base;
    logic [SEL_W-1:0]      sel_c;
    logic [BCW-1:0]        burst_cnt;
    logic                  started, region_done, req, busy;
    logic                  in_burst, burst_end, last_burst, push, pop, room;

    // Out-of-range region indices fall back to the last region.
    assign sel_c       = (32'(i_region_sel) >= NUM_REGIONS) ? SEL_W'(NUM_REGIONS - 1) : i_region_sel;
    assign region_base = BASE_A + ADDR_SIZE'(sel_c) * ADDR_SIZE'(REGION_STRIDE);

    assign in_burst   = (state == REQ) || (state == DATA);
    assign burst_end  = in_burst && bus.rd_burst_finish;
    assign last_burst = (burst_cnt == BCW'(REGION_BURSTS - 1));
    // A beat arriving together with an abort is already part of the discarded tail.
    assign push       = in_burst && bus.rd_burst_valid && !load_w_finish;
    assign pop        = bus.i_weight_valid && (count != '0);
    // Only a request for a whole burst is issued, so the FIFO can never overflow.
    assign room       = 32'(count) <= (FIFO_DEPTH - BURST_LEN);
    assign rd_nx      = rd_ptr + 1'b1;

    assign bus.rd_burst_addr  = addr;
    assign bus.rd_burst_len   = LEN_WIDTH'(BURST_LEN);
    assign bus.rd_burst_req   = req;
    assign bus.o_weight_out   = head;
    assign bus.o_empty        = (count == '0);
    assign bus.o_weight_ready = 32'(count) >= PROG_EMPTY;
    assign o_busy             = busy;
    assign o_region_done      = region_done;

    // FSM state register.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and request/busy decode. A finish seen in REQ (single-beat
    // burst) completes the burst directly so the FSM cannot stall in DATA.
    always_comb begin
        state_nx = state;
        req      = (state == REQ);
        busy     = (state != IDLE);
        case (state)
            IDLE: begin
                if (load_w_finish) state_nx = FLUSH;
                else if (i_start)  state_nx = CHECK;
            end
            CHECK: begin
                if (load_w_finish) state_nx = FLUSH;
                else if (room)     state_nx = REQ;
            end
            REQ, DATA: begin
                if (burst_end) begin
                    if (load_w_finish)                     state_nx = FLUSH;
                    else if (last_burst && WRAP_MODE == 0) state_nx = IDLE;
                    else                                   state_nx = CHECK;
                end else if (load_w_finish) begin
                    state_nx = DRAIN;
                end else if (state == REQ && bus.rd_burst_valid) begin
                    state_nx = DATA;
                end
            end
            DRAIN:   if (bus.rd_burst_finish) state_nx = FLUSH;
            FLUSH:   state_nx = started ? CHECK : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Region base latch, burst address walk, burst counter and done pulse.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            base        <= BASE_A;
            addr        <= BASE_A;
            burst_cnt   <= '0;
            started     <= 1'b0;
            region_done <= 1'b0;
        end else begin
            region_done <= 1'b0;
            if (state == IDLE && i_start) begin
                base    <= region_base;
                addr    <= region_base;
                started <= 1'b1;
            end else if (state == FLUSH) begin
                burst_cnt <= '0;
                addr      <= base;
            end else if (burst_end && !load_w_finish) begin
                if (last_burst) begin
                    burst_cnt   <= '0;
                    addr        <= base;
                    region_done <= 1'b1;
                    if (WRAP_MODE == 0) started <= 1'b0;
                end else begin
                    burst_cnt <= burst_cnt + 1'b1;
                    addr      <= addr + BURST_BYTES;
                end
            end
        end
    end

    // FIFO storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge s_clk) begin
        if (push) mem[wr_ptr] <= bus.rd_burst_data;
    end

    // FIFO pointers, occupancy and the registered head word.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n || state == FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_nx;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // The incoming beat becomes the head when it lands in an empty
            // (or just emptied) FIFO; it is not yet readable from mem.
            if (push && (count == '0 || (pop && count == CW'(1))))
                head <= bus.rd_burst_data;
            else if (pop && count > CW'(1))
                head <= mem[rd_nx];
        end
    end

`ifdef WEIGHT_FIFO_STAT_EN
    // Saturating underflow and completed-burst counters, cleared per run.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n || i_start) begin
            o_underflow_cnt <= '0;
            o_burst_cnt     <= '0;
        end else begin
            if (bus.i_weight_valid && count == '0 && o_underflow_cnt != '1)
                o_underflow_cnt <= o_underflow_cnt + 1'b1;
            if (burst_end && !load_w_finish && o_burst_cnt != '1)
                o_burst_cnt <= o_burst_cnt + 1'b1;
        end
    end
`endif
endmodule
